uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frame (start, 8 data bits LSB first, parity or
// second stop, stop). Bit timing comes from an external one-clk baud_trig
// strobe shared with the receiver. The line output is registered and lags
// the state machine by exactly one clk, which keeps every bit one baud
// period long.
module uart_tx #(
   parameter int PARITY_EN  = 1,  // 1: bit9 is parity, 0: bit9 is a second stop bit
   parameter int PARITY_ODD = 0   // 1: odd parity, 0: even parity
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_trig,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       done_tx
);

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t     state_reg,  state_next;
   logic [7:0] shift_reg,  shift_next;
   logic [2:0] count_reg,  count_next;
   logic       parity_reg, parity_next;
   logic       tx_reg,     tx_next;
   logic       busy_reg,   busy_next;
   logic       done_reg,   done_next;

   // A new byte can only be taken while nothing is in flight.
   assign tx_ready = (state_reg == IDLE);
   assign tx       = tx_reg;
   assign busy     = busy_reg;
   assign done_tx  = done_reg;

   // State and datapath registers; reset aborts any frame and idles the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         shift_reg  <= 8'h00;
         count_reg  <= 3'd0;
         parity_reg <= 1'b0;
         tx_reg     <= 1'b1;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         count_reg  <= count_next;
         parity_reg <= parity_next;
         tx_reg     <= tx_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   // Next-state and line-level logic. The line value is derived from the
   // current state, so it appears on tx one clk after the state changes.
   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      count_next  = count_reg;
      parity_next = parity_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      tx_next     = 1'b1;

      case (state_reg)
         IDLE: begin
            // baud_trig is deliberately ignored here: even a coinciding
            // strobe must not start the frame, ALIGN waits for the next one.
            tx_next = 1'b1;
            if (tx_valid) begin
               shift_next  = tx_data;
               parity_next = (^tx_data) ^ (PARITY_ODD != 0);
               busy_next   = 1'b1;
               state_next  = ALIGN;
            end
         end

         ALIGN: begin
            // Hold the line idle until a bit boundary so the start bit is
            // a full baud period long.
            tx_next = 1'b1;
            if (baud_trig) begin
               state_next = START;
            end
         end

         START: begin
            tx_next = 1'b0;
            if (baud_trig) begin
               count_next = 3'd0;
               state_next = DATA;
            end
         end

         DATA: begin
            tx_next = shift_reg[0];
            if (baud_trig) begin
               shift_next = {1'b0, shift_reg[7:1]};
               count_next = count_reg + 3'd1;
               if (count_reg == 3'd7) begin
                  state_next = PAR;
               end
            end
         end

         PAR: begin
            tx_next = (PARITY_EN != 0) ? parity_reg : 1'b1;
            if (baud_trig) begin
               state_next = STOP;
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (baud_trig) begin
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even parity, odd parity, no parity)
// share one stimulus stream. Accepted bytes go into a scoreboard; a line
// monitor decodes each tx line at the baud strobes like a receiver would and
// compares the frames against a reference frame built from the byte.
module tb_uart_tx;

   localparam int N    = 3;
   localparam int BAUD = 6;
   localparam int TMO  = 3000;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       baud_trig = 1'b0;
   logic       tx_valid  = 1'b0;
   logic [7:0] tx_data   = 8'h00;

   logic tx_w    [N];
   logic ready_w [N];
   logic busy_w  [N];
   logic done_w  [N];

   int checks = 0;
   int errors = 0;

   // scoreboard: accepted bytes and the baud-strobe count at acceptance
   logic [7:0] exp_data [$];
   int         exp_trig [$];

   int          rd         [N];
   logic        dec_active [N];
   int          dec_idx    [N];
   logic [10:0] dec_frame  [N];
   logic [10:0] last_frame [N];
   logic        done_due   [N];
   logic        tx_prev    [N];
   int          frames     [N];
   int          done_cnt   [N];
   int          tog_cnt    [N];

   int         trig_cnt = 0;
   int         acc_cnt  = 0;
   int         baud_div = 0;
   logic [1:0] bt_hist  = 2'b00;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      uart_tx #(
         .PARITY_EN  ((gi == 2) ? 0 : 1),
         .PARITY_ODD ((gi == 1) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .baud_trig (baud_trig),
         .tx_valid  (tx_valid),
         .tx_data   (tx_data),
         .tx_ready  (ready_w[gi]),
         .tx        (tx_w[gi]),
         .busy      (busy_w[gi]),
         .done_tx   (done_w[gi])
      );
   end

   initial forever #5 clk = ~clk;

   // free-running baud strobe, one clk wide every BAUD clks
   initial begin
      forever begin
         @(posedge clk);
         #1;
         baud_div  = (baud_div + 1) % BAUD;
         baud_trig = (baud_div == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // reference frame, bit k = k-th bit on the wire
   function automatic logic [10:0] model_frame(input logic [7:0] b, input int inst);
      int   ones;
      logic b9;
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(b[k]);
      if (inst == 2)      b9 = 1'b1;                 // no parity: second stop bit
      else if (inst == 1) b9 = ((ones % 2) == 0);    // odd parity
      else                b9 = ((ones % 2) == 1);    // even parity
      return {1'b1, b9, b, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // line monitor / scoreboard checker
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < N; i++) begin
               dec_active[i] = 1'b0;
               done_due[i]   = 1'b0;
               tx_prev[i]    = 1'b1;
               rd[i]         = exp_data.size();
            end
            bt_hist = 2'b00;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (tx_w[i] !== tx_prev[i]) begin
                  tog_cnt[i]++;
                  chk($sformatf("edge_after_trig[%0d]", i), 32'(bt_hist[1]), 32'd1);
               end
               tx_prev[i] = tx_w[i];
               chk($sformatf("ready_vs_busy[%0d]", i), 32'(ready_w[i]), 32'(!busy_w[i]));
               if (done_w[i] || done_due[i]) begin
                  chk($sformatf("done_pulse[%0d]", i), 32'(done_w[i]), 32'(done_due[i]));
                  if (done_w[i]) done_cnt[i]++;
                  if (done_due[i]) chk($sformatf("busy_at_done[%0d]", i), 32'(busy_w[i]), 32'd0);
               end
               done_due[i] = 1'b0;
               if (baud_trig) begin
                  if (!dec_active[i]) begin
                     if (tx_w[i] == 1'b0) begin
                        if (rd[i] >= exp_data.size()) begin
                           chk($sformatf("start_without_accept[%0d]", i), 32'(tx_w[i]), 32'd1);
                        end else begin
                           chk($sformatf("start_latency[%0d]", i), 32'(trig_cnt - exp_trig[rd[i]]), 32'd1);
                           dec_active[i] = 1'b1;
                           dec_idx[i]    = 1;
                           dec_frame[i]  = 11'h000;
                        end
                     end
                  end else begin
                     dec_frame[i][dec_idx[i]] = tx_w[i];
                     dec_idx[i]++;
                     if (dec_idx[i] == 11) begin
                        chk($sformatf("frame[%0d] byte %0h", i, exp_data[rd[i]]),
                            32'(dec_frame[i]), 32'(model_frame(exp_data[rd[i]], i)));
                        last_frame[i] = dec_frame[i];
                        rd[i]++;
                        frames[i]++;
                        done_due[i]   = 1'b1;
                        dec_active[i] = 1'b0;
                     end
                  end
               end
            end
            if (tx_valid && ready_w[0]) begin
               exp_data.push_back(tx_data);
               exp_trig.push_back(trig_cnt + (baud_trig ? 1 : 0));
               acc_cnt++;
            end
            if (baud_trig) trig_cnt++;
            bt_hist = {bt_hist[0], baud_trig};
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int a;
      int n;
      a        = acc_cnt;
      n        = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (acc_cnt == a && n < TMO) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (acc_cnt == a) chk("accept_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(rd[0] == exp_data.size() && !dec_active[0] && ready_w[0]) && n < TMO) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= TMO) chk("idle_timeout", 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // position stimulus so that tx_valid is high at a baud_trig edge
   task automatic align_to_trig();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!baud_trig && n < 4 * BAUD);
      @(posedge clk);
      repeat (BAUD - 1) @(posedge clk);
      #1;
   endtask

   initial begin
      int         t0  [N];
      int         d0;
      int         target;
      int         n;
      logic [7:0] b;

      for (int i = 0; i < N; i++) begin
         rd[i] = 0; dec_active[i] = 1'b0; dec_idx[i] = 0; dec_frame[i] = '0;
         last_frame[i] = '0; done_due[i] = 1'b0; tx_prev[i] = 1'b1;
         frames[i] = 0; done_cnt[i] = 0; tog_cnt[i] = 0;
      end

      // reset and idle behaviour
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset_tx[%0d]", i),    32'(tx_w[i]),    32'd1);
         chk($sformatf("reset_ready[%0d]", i), 32'(ready_w[i]), 32'd1);
         chk($sformatf("reset_busy[%0d]", i),  32'(busy_w[i]),  32'd0);
         chk($sformatf("reset_done[%0d]", i),  32'(done_w[i]),  32'd0);
         t0[i] = tog_cnt[i];
      end
      repeat (20 * BAUD) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         chk($sformatf("idle_no_toggle[%0d]", i), 32'(tog_cnt[i] - t0[i]), 32'd0);

      // 0xA5 with even parity
      send(8'hA5);
      wait_idle();
      chk("a5_even_frame", 32'(last_frame[0]), 32'(11'b10101001010));

      // 0x07: odd parity bit 0, no-parity bit9 1, even parity bit 1
      send(8'h07);
      wait_idle();
      chk("07_even_bit9",  32'(last_frame[0][9]), 32'd1);
      chk("07_odd_bit9",   32'(last_frame[1][9]), 32'd0);
      chk("07_nopar_bit9", 32'(last_frame[2][9]), 32'd1);

      // held tx_valid: 0x3C then 0xC3, data changes while busy
      d0 = done_cnt[0];
      send(8'h3C);
      send(8'hC3);
      wait_idle();
      chk("held_two_done", 32'(done_cnt[0] - d0), 32'd2);
      chk("held_first_byte",  32'(exp_data[exp_data.size() - 2]), 32'h3C);
      chk("held_second_byte", 32'(exp_data[exp_data.size() - 1]), 32'hC3);

      // acceptance coinciding with baud_trig
      align_to_trig();
      send(8'h5A);
      wait_idle();

      // reset during data bit 4 of 0xE7 (bit4 = 0)
      send(8'hE7);
      target = exp_trig[exp_trig.size() - 1] + 6;
      n = 0;
      while (trig_cnt < target && n < TMO) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("bit4_before_rst", 32'(tx_w[0]), 32'd0);
      d0 = done_cnt[0];
      rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("abort_tx[%0d]", i),    32'(tx_w[i]),    32'd1);
         chk($sformatf("abort_busy[%0d]", i),  32'(busy_w[i]),  32'd0);
         chk($sformatf("abort_ready[%0d]", i), 32'(ready_w[i]), 32'd1);
         chk($sformatf("abort_done[%0d]", i),  32'(done_w[i]),  32'd0);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (12 * BAUD) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
      send(8'h55);
      wait_idle();
      chk("after_abort_byte", 32'(last_frame[0][8:1]), 32'h55);

      // loopback-style byte set, back to back
      send(8'h00);
      send(8'hFF);
      send(8'h81);
      wait_idle();
      chk("loop_last_byte", 32'(last_frame[2][8:1]), 32'h81);

      // randomized traffic
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            align_to_trig();
         end
         send(b);
         n = $urandom_range(0, 2 * BAUD);
         if (n > 0) repeat (n) @(posedge clk);
         #1;
      end
      wait_idle();

      for (int i = 0; i < N; i++) begin
         chk($sformatf("all_frames[%0d]", i), 32'(rd[i]), 32'(exp_data.size()));
         chk($sformatf("done_count[%0d]", i), 32'(done_cnt[i]), 32'(frames[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
